// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared register-file constants and index type for the core.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

  localparam int REG_WIDTH = 32;
  localparam int REG_DEPTH = 32;
  localparam int REG_AW    = $clog2(REG_DEPTH);
  localparam int REG_ZERO  = 0;

  // Direct register index (no byte-address shifting)
  typedef logic [REG_AW-1:0] reg_idx_t;

endpackage
`default_nettype wire

// File: rtl/rf_read_port.sv
`default_nettype none
// ============================================================================
//  Module      : rf_read_port
//  Description : One register-file read port: hardwired zero, write-to-read
//                bypass and busy masking for a value delivered this cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module rf_read_port
  import mips_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH,
  parameter int AW    = REG_AW
) (
  input  logic [AW-1:0]    raddr_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [WIDTH-1:0] reg_data_i,
  input  logic             busy_bit_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             rbusy_o
);

  logic w_is_zero;
  logic w_hit;

  assign w_is_zero = (raddr_i == AW'(REG_ZERO));
  assign w_hit     = we_i && (waddr_i == raddr_i);

  // Select zero, bypassed writeback data, or stored data; mask busy on bypass
  always_comb begin
    rdata_o = reg_data_i;
    rbusy_o = busy_bit_i;
    if (w_is_zero) begin
      rdata_o = '0;
      rbusy_o = 1'b0;
    end else if (w_hit) begin
      rdata_o = wdata_i;
      rbusy_o = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_sb
//  Description : General-purpose register file with two combinational read
//                ports, one write port, bypass, hardwired r0 and a busy
//                scoreboard with a registered busy count.
//  Revision    : 1.0  initial release
// ============================================================================
module reg_file_sb
  import mips_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH,
  parameter int DEPTH = REG_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    raddr1,
  input  logic [AW-1:0]    raddr2,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2,
  output logic             rbusy1,
  output logic             rbusy2,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             set_busy,
  input  logic [AW-1:0]    set_addr,
  input  logic             flush,
  output logic [AW:0]      busy_cnt
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [AW:0]      cnt_q;
  logic [AW:0]      cnt_d;

  logic w_wr_valid;
  logic w_set_valid;
  logic w_inc;
  logic w_dec;

  assign w_wr_valid  = we && (waddr != AW'(REG_ZERO));
  assign w_set_valid = set_busy && (set_addr != AW'(REG_ZERO));

  // Register array: r0 is never written so it stays at its reset value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (w_wr_valid) begin
      regs_q[waddr] <= wdata;
    end
  end

  // Next busy vector: flush clears all; set is applied after clear so it wins
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (w_wr_valid) begin
        busy_d[waddr] = 1'b0;
      end
      if (w_set_valid) begin
        busy_d[set_addr] = 1'b1;
      end
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  // Incremental population count: only real 0->1 / 1->0 transitions count
  always_comb begin
    w_inc = !flush && w_set_valid && !busy_q[set_addr];
    w_dec = !flush && w_wr_valid && busy_q[waddr]
            && !(w_set_valid && (set_addr == waddr));
    if (flush) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + (AW+1)'(w_inc) - (AW+1)'(w_dec);
    end
  end

  // Scoreboard state and busy count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

  rf_read_port #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_port1 (
    .raddr_i    (raddr1),
    .we_i       (we),
    .waddr_i    (waddr),
    .wdata_i    (wdata),
    .reg_data_i (regs_q[raddr1]),
    .busy_bit_i (busy_q[raddr1]),
    .rdata_o    (rdata1),
    .rbusy_o    (rbusy1)
  );

  rf_read_port #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_port2 (
    .raddr_i    (raddr2),
    .we_i       (we),
    .waddr_i    (waddr),
    .wdata_i    (wdata),
    .reg_data_i (regs_q[raddr2]),
    .busy_bit_i (busy_q[raddr2]),
    .rdata_o    (rdata2),
    .rbusy_o    (rbusy2)
  );

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file_sb
//  Description : Directed self-checking bench for reg_file_sb.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reg_file_sb;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic             clk;
  logic             rst;
  logic [AW-1:0]    raddr1;
  logic [AW-1:0]    raddr2;
  logic [WIDTH-1:0] rdata1;
  logic [WIDTH-1:0] rdata2;
  logic             rbusy1;
  logic             rbusy2;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic             set_busy;
  logic [AW-1:0]    set_addr;
  logic             flush;
  logic [AW:0]      busy_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  reg_file_sb #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .raddr1   (raddr1),
    .raddr2   (raddr2),
    .rdata1   (rdata1),
    .rdata2   (rdata2),
    .rbusy1   (rbusy1),
    .rbusy2   (rbusy2),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .set_busy (set_busy),
    .set_addr (set_addr),
    .flush    (flush),
    .busy_cnt (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    we       = 1'b0;
    waddr    = '0;
    wdata    = '0;
    set_busy = 1'b0;
    set_addr = '0;
    flush    = 1'b0;
  endtask

  // Inputs change on the falling edge; outputs sampled 1 ns later
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    raddr1 = '0;
    raddr2 = '0;
    rst = 1'b1;
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      raddr1 = AW'(i);
      raddr2 = AW'(DEPTH - 1 - i);
      #1;
      n_checks++;
      if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_rdata idx %0d: got %h/%h expected 0", i, rdata1, rdata2);
      end
      n_checks++;
      if (rbusy1 !== 1'b0 || rbusy2 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_rbusy idx %0d: got %b/%b expected 0", i, rbusy1, rbusy2);
      end
    end
    n_checks++;
    if (busy_cnt !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_busy_cnt: got %0d expected 0", busy_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_bypass_write();
    @(negedge clk);
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    raddr1 = 5'd5; raddr2 = 5'd5;
    #1;
    n_checks++;
    if (rdata1 !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL bypass_rdata1: got %h expected deadbeef", rdata1);
    end
    n_checks++;
    if (rdata2 !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL bypass_rdata2: got %h expected deadbeef", rdata2);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++;
    if (rdata1 !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL stored_rdata1: got %h expected deadbeef", rdata1);
    end
    raddr2 = 5'd6;
    #1;
    n_checks++;
    if (rdata2 !== 32'h0) begin
      n_fail++;
      $display("FAIL untouched_r6: got %h expected 0", rdata2);
    end
  endtask

  task automatic test_r0();
    @(negedge clk);
    we = 1'b1; waddr = 5'd0; wdata = 32'h12345678;
    set_busy = 1'b1; set_addr = 5'd0;
    raddr1 = 5'd0; raddr2 = 5'd0;
    #1;
    n_checks++;
    if (rdata1 !== 32'h0 || rbusy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL r0_same_cycle: got %h/%b expected 0/0", rdata1, rbusy1);
    end
    step();
    idle_inputs();
    #1;
    n_checks++;
    if (rdata2 !== 32'h0 || rbusy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL r0_after_edge: got %h/%b expected 0/0", rdata2, rbusy2);
    end
    n_checks++;
    if (busy_cnt !== 6'd0) begin
      n_fail++;
      $display("FAIL r0_busy_cnt: got %0d expected 0", busy_cnt);
    end
  endtask

  task automatic test_busy_set_clear();
    @(negedge clk);
    set_busy = 1'b1; set_addr = 5'd3; raddr1 = 5'd3;
    #1;
    n_checks++;
    if (rbusy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL set_not_bypassed: got %b expected 0", rbusy1);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++;
    if (rbusy1 !== 1'b1 || busy_cnt !== 6'd1) begin
      n_fail++;
      $display("FAIL set_r3: got rbusy %b cnt %0d expected 1/1", rbusy1, busy_cnt);
    end
    @(negedge clk);
    we = 1'b1; waddr = 5'd3; wdata = 32'h55;
    #1;
    n_checks++;
    if (rbusy1 !== 1'b0 || rdata1 !== 32'h55) begin
      n_fail++;
      $display("FAIL clear_r3_bypass: got %b/%h expected 0/00000055", rbusy1, rdata1);
    end
    n_checks++;
    if (busy_cnt !== 6'd1) begin
      n_fail++;
      $display("FAIL clear_r3_cnt_before: got %0d expected 1", busy_cnt);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++;
    if (busy_cnt !== 6'd0 || rbusy1 !== 1'b0 || rdata1 !== 32'h55) begin
      n_fail++;
      $display("FAIL clear_r3_after: got cnt %0d rbusy %b data %h expected 0/0/00000055",
               busy_cnt, rbusy1, rdata1);
    end
  endtask

  task automatic test_same_cycle();
    // set and clear on the same register: set wins
    @(negedge clk);
    set_busy = 1'b1; set_addr = 5'd7;
    we = 1'b1; waddr = 5'd7; wdata = 32'hA;
    raddr1 = 5'd7; raddr2 = 5'd9;
    #1;
    n_checks++;
    if (rdata1 !== 32'hA || rbusy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL same_addr_bypass: got %h/%b expected 0000000a/0", rdata1, rbusy1);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++;
    if (rbusy1 !== 1'b1 || busy_cnt !== 6'd1 || rdata1 !== 32'hA) begin
      n_fail++;
      $display("FAIL same_addr_set_wins: got rbusy %b cnt %0d data %h expected 1/1/0000000a",
               rbusy1, busy_cnt, rdata1);
    end
    // set r9 while clearing r7: both take effect, count unchanged
    @(negedge clk);
    set_busy = 1'b1; set_addr = 5'd9;
    we = 1'b1; waddr = 5'd7; wdata = 32'hB;
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++;
    if (rbusy1 !== 1'b0 || rbusy2 !== 1'b1 || busy_cnt !== 6'd1) begin
      n_fail++;
      $display("FAIL diff_addr: got r7 %b r9 %b cnt %0d expected 0/1/1", rbusy1, rbusy2, busy_cnt);
    end
    // re-setting an already busy register does not increment
    @(negedge clk);
    set_busy = 1'b1; set_addr = 5'd9;
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++;
    if (busy_cnt !== 6'd1) begin
      n_fail++;
      $display("FAIL reset_busy_no_inc: got %0d expected 1", busy_cnt);
    end
    @(negedge clk);
    we = 1'b1; waddr = 5'd9; wdata = 32'h99;
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++;
    if (busy_cnt !== 6'd0 || rbusy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_r9: got cnt %0d rbusy %b expected 0/0", busy_cnt, rbusy2);
    end
  endtask

  task automatic test_flush();
    for (int r = 1; r <= 3; r++) begin
      @(negedge clk);
      set_busy = 1'b1; set_addr = AW'(r);
    end
    @(negedge clk);
    idle_inputs();
    raddr1 = 5'd2; raddr2 = 5'd3;
    #1;
    n_checks++;
    if (busy_cnt !== 6'd3 || rbusy1 !== 1'b1 || rbusy2 !== 1'b1) begin
      n_fail++;
      $display("FAIL three_busy: got cnt %0d rbusy %b/%b expected 3/1/1", busy_cnt, rbusy1, rbusy2);
    end
    flush = 1'b1; set_busy = 1'b1; set_addr = 5'd4;
    we = 1'b1; waddr = 5'd10; wdata = 32'h77;
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++;
    if (busy_cnt !== 6'd0) begin
      n_fail++;
      $display("FAIL flush_cnt: got %0d expected 0", busy_cnt);
    end
    for (int r = 1; r <= 4; r++) begin
      raddr1 = AW'(r);
      #1;
      n_checks++;
      if (rbusy1 !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_rbusy r%0d: got %b expected 0", r, rbusy1);
      end
    end
    raddr2 = 5'd10;
    #1;
    n_checks++;
    if (rdata2 !== 32'h77) begin
      n_fail++;
      $display("FAIL flush_data_write: got %h expected 00000077", rdata2);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_busy = 1'b1; set_addr = 5'd5;
    @(negedge clk);
    idle_inputs();
    raddr1 = 5'd5; raddr2 = 5'd10;
    #1;
    n_checks++;
    if (busy_cnt !== 6'd1 || rbusy1 !== 1'b1 || rdata1 !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL pre_reset: got cnt %0d rbusy %b data %h expected 1/1/deadbeef",
               busy_cnt, rbusy1, rdata1);
    end
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0 || rbusy1 !== 1'b0 || busy_cnt !== 6'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %h %h %b %0d expected all 0", rdata1, rdata2, rbusy1, busy_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (rdata1 !== 32'h0 || busy_cnt !== 6'd0) begin
      n_fail++;
      $display("FAIL post_reset: got %h %0d expected 0/0", rdata1, busy_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_bypass_write();
    test_r0();
    test_busy_set_clear();
    test_same_cycle();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
